// File: rtl/mem_pkg.sv
// Shared definitions for the cache memory side: responder states, default
// geometry and the byte-address to word-index mapping.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam int DEF_LATENCY    = 4;

  // Word index is the byte address with the two byte-offset bits dropped,
  // truncated to the storage depth so higher addresses alias.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int depth_log2);
    return (addr >> 2) & ((32'd1 << depth_log2) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered read; the read register
// holds its value until the next read access.
module mem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      else    rdata    <= mem[idx];
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache refill/write-back path: one outstanding
// word request, answered after a fixed latency, with read/write statistics.
module cache_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_wr,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic                  wr_q;
  logic                  accept;
  logic                  resp_active;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     cur_rdata;
  logic [DATA_W-1:0]     rdata_hold;
  logic                  wr_hold;

  assign idx       = DEPTH_LOG2'(word_index(32'(req_addr), DEPTH_LOG2));
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE) && !rst;

  mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .en    (accept),
    .we    (req_wr),
    .idx   (idx),
    .wdata (req_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
          cnt_nxt   = 8'(LATENCY - 1);
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // During the response cycle the outputs come straight from the RAM read
  // register (needed for LATENCY=1); afterwards a hold copy keeps them stable.
  assign resp_active = (state == RESP) && !rst;
  assign cur_rdata   = wr_q ? '0 : mem_rdata;
  assign resp_valid  = resp_active;
  assign resp_wr     = resp_active ? wr_q : wr_hold;
  assign resp_rdata  = resp_active ? cur_rdata : rdata_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      wr_hold    <= 1'b0;
      rdata_hold <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        wr_q <= req_wr;
        if (req_wr) wr_count <= wr_count + 32'd1;
        else        rd_count <= rd_count + 32'd1;
      end
      if (resp_active) begin
        wr_hold    <= wr_q;
        rdata_hold <= cur_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: a LATENCY=4 instance and a
// LATENCY=1 instance driven with directed requests.
module tb_cache_mem_responder;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  int          resp_seen0 = 0;
  int          resp_seen1 = 0;
  int          er0 = 0, ew0 = 0, er1 = 0, ew1 = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  logic        req_valid0 = 1'b0, req_wr0 = 1'b0;
  logic [31:0] req_addr0 = '0, req_wdata0 = '0;
  logic        req_ready0, resp_valid0, resp_wr0;
  logic [31:0] resp_rdata0, rd_count0, wr_count0;

  logic        req_valid1 = 1'b0, req_wr1 = 1'b0;
  logic [31:0] req_addr1 = '0, req_wdata1 = '0;
  logic        req_ready1, resp_valid1, resp_wr1;
  logic [31:0] resp_rdata1, rd_count1, wr_count1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_wr(req_wr0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_wr(resp_wr0), .resp_rdata(resp_rdata0),
    .rd_count(rd_count0), .wr_count(wr_count0));

  cache_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_wr(req_wr1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_wr(resp_wr1), .resp_rdata(resp_rdata1),
    .rd_count(rd_count1), .wr_count(wr_count1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pops one expectation and checks data, type and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid0) begin
      resp_seen0++;
      if (q0.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_resp0 cycle=%0d rdata=0x%08h", cyc, resp_rdata0);
      end else begin
        e = q0.pop_front();
        chk("resp0_rdata", resp_rdata0, e.rdata);
        chk("resp0_wr", 32'(resp_wr0), 32'(e.wr));
        chk("resp0_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (resp_valid1) begin
      resp_seen1++;
      if (q1.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_resp1 cycle=%0d rdata=0x%08h", cyc, resp_rdata1);
      end else begin
        e = q1.pop_front();
        chk("resp1_rdata", resp_rdata1, e.rdata);
        chk("resp1_wr", 32'(resp_wr1), 32'(e.wr));
        chk("resp1_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Presents a request (left asserted on return) and waits for acceptance.
  task automatic do_req(input int u, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input bit expect_resp, output int acc_cyc);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    if (u == 0) begin
      req_valid0 = 1'b1; req_wr0 = wr; req_addr0 = addr; req_wdata0 = wdata;
    end else begin
      req_valid1 = 1'b1; req_wr1 = wr; req_addr1 = addr; req_wdata1 = wdata;
    end
    while (!((u == 0) ? req_ready0 : req_ready1) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      checks++; fails++;
      $display("FAIL accept_timeout unit=%0d actual=not_ready expected=ready", u);
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc;
    e.wr    = wr;
    e.rdata = wr ? 32'd0 : exp_rdata;
    e.due   = cyc + ((u == 0) ? 4 : 1);
    if (expect_resp) begin
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    if (u == 0) begin
      if (wr) ew0++; else er0++;
    end else begin
      if (wr) ew1++; else er1++;
    end
    @(posedge clk);
  endtask

  task automatic release_req();
    @(negedge clk);
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((q0.size() != 0 || q1.size() != 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
  endtask

  task automatic chk_counts();
    chk("rd_count0", rd_count0, 32'(er0));
    chk("wr_count0", wr_count0, 32'(ew0));
    chk("rd_count1", rd_count1, 32'(er1));
    chk("wr_count1", wr_count1, 32'(ew1));
  endtask

  initial begin
    int a0, a1, a2, seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_req_ready0", 32'(req_ready0), 32'd1);
    chk("rst_resp_valid0", 32'(resp_valid0), 32'd0);
    chk("rst_resp_rdata0", resp_rdata0, 32'd0);
    chk("rst_resp_wr0", 32'(resp_wr0), 32'd0);
    chk("rst_req_ready1", 32'(req_ready1), 32'd1);
    chk_counts();

    // Write then read back the same word.
    do_req(0, 1'b1, 32'h1004_0024, 32'h0000_0001, 32'h0, 1'b1, a0);
    do_req(0, 1'b0, 32'h1004_0024, 32'h0, 32'h0000_0001, 1'b1, a1);
    release_req();
    drain();
    chk("wr_rd_spacing", 32'(a1 - a0), 32'd5);
    chk_counts();
    chk("rdata_hold", resp_rdata0, 32'h0000_0001);

    // Two addresses sharing index 0x009.
    do_req(0, 1'b1, 32'h1004_0024, 32'h0000_000A, 32'h0, 1'b1, a0);
    do_req(0, 1'b1, 32'h0000_1024, 32'h0000_000B, 32'h0, 1'b1, a0);
    release_req();
    drain();
    chk("wr_rdata_zero", resp_rdata0, 32'd0);
    chk("wr_resp_wr_hold", 32'(resp_wr0), 32'd1);

    // Three reads with req_valid held high throughout.
    do_req(0, 1'b0, 32'h1004_0024, 32'h0, 32'h0000_000B, 1'b1, a0);
    do_req(0, 1'b0, 32'h1004_0024, 32'h0, 32'h0000_000B, 1'b1, a1);
    do_req(0, 1'b0, 32'h1004_0024, 32'h0, 32'h0000_000B, 1'b1, a2);
    release_req();
    drain();
    chk("hold_spacing_1", 32'(a1 - a0), 32'd5);
    chk("hold_spacing_2", 32'(a2 - a1), 32'd5);
    chk_counts();

    // Reset two cycles into a write to index 3; a request during reset is ignored.
    do_req(0, 1'b1, 32'h0000_000C, 32'h0000_0055, 32'h0, 1'b0, a0);
    seen = resp_seen0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid0 = 1'b1; req_wr0 = 1'b1; req_addr0 = 32'h0000_000C; req_wdata0 = 32'h0000_0099;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid0 = 1'b0;
    er0 = 0; ew0 = 0; er1 = 0; ew1 = 0;
    repeat (6) @(negedge clk);
    chk("rst_drop_resp", 32'(resp_seen0 - seen), 32'd0);
    chk("rst_req_ready0_b", 32'(req_ready0), 32'd1);
    chk_counts();
    do_req(0, 1'b0, 32'h0000_000C, 32'h0, 32'h0000_0055, 1'b1, a0);
    release_req();
    drain();
    chk_counts();

    // LATENCY=1 instance: one acceptance every two cycles.
    do_req(1, 1'b1, 32'h0000_0040, 32'h0000_1234, 32'h0, 1'b1, a0);
    do_req(1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_1234, 1'b1, a0);
    do_req(1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_1234, 1'b1, a1);
    do_req(1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_1234, 1'b1, a2);
    release_req();
    drain();
    chk("lat1_spacing_1", 32'(a1 - a0), 32'd2);
    chk("lat1_spacing_2", 32'(a2 - a1), 32'd2);
    chk_counts();

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
